// File: rtl/chart_scroll_ctrl.sv
// Paces chart rows from ROM to the highway renderer: one row per TICKS_PER_ROW frame ticks.
// ROM read takes FETCH+WAIT (2 cycles); OFFER holds row_data/row_valid until row_ready.
module chart_scroll_ctrl #(
   parameter int WIDTH         = 8,
   parameter int DEPTH         = 2240,
   parameter int TICKS_PER_ROW = 4,
   localparam int AW           = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             pause,
   input  logic             frame_tick,
   output logic             rom_en,
   output logic [AW-1:0]    rom_addr,
   input  logic [WIDTH-1:0] rom_data,
   output logic [WIDTH-1:0] row_data,
   output logic             row_valid,
   input  logic             row_ready,
   output logic [AW-1:0]    row_index,
   output logic             playing,
   output logic             done,
   output logic             overrun
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_RUN    = 3'd1;
   localparam logic [2:0] S_PAUSED = 3'd2;
   localparam logic [2:0] S_FETCH  = 3'd3;
   localparam logic [2:0] S_WAIT   = 3'd4;
   localparam logic [2:0] S_OFFER  = 3'd5;
   localparam logic [2:0] S_DONE   = 3'd6;

   localparam logic [7:0]    TICK_MAX = 8'(TICKS_PER_ROW);
   localparam logic [AW-1:0] LAST_ROW = AW'(DEPTH - 1);

   logic [2:0] state;
   logic [2:0] state_nx;
   logic [7:0] tick_cnt;
   logic       counting;
   logic       tick_full;
   logic       launch;
   logic       handshake;
   logic       fetch_go;

   assign counting  = (state == S_RUN) || (state == S_FETCH) ||
                      (state == S_WAIT) || (state == S_OFFER);
   assign tick_full = (tick_cnt == TICK_MAX);
   assign launch    = ((state == S_IDLE) || (state == S_DONE)) && start;
   assign handshake = (state == S_OFFER) && row_valid && row_ready;
   assign fetch_go  = (state == S_RUN) && !pause && tick_full;
   assign rom_addr  = row_index;

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE, S_DONE: if (start) state_nx = S_RUN;
         S_RUN: begin
            if (pause)          state_nx = S_PAUSED;
            else if (tick_full) state_nx = S_FETCH;
         end
         S_PAUSED: if (!pause) state_nx = S_RUN;
         S_FETCH:  state_nx = S_WAIT;
         S_WAIT:   state_nx = S_OFFER;
         S_OFFER: begin
            if (handshake) state_nx = (row_index == LAST_ROW) ? S_DONE : S_RUN;
         end
         default:  state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         row_index <= '0;
         tick_cnt  <= '0;
         row_data  <= '0;
         row_valid <= 1'b0;
         rom_en    <= 1'b0;
         playing   <= 1'b0;
         done      <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         state   <= state_nx;
         rom_en  <= (state_nx == S_FETCH);
         playing <= (state_nx == S_RUN) || (state_nx == S_FETCH) ||
                    (state_nx == S_WAIT) || (state_nx == S_OFFER);
         done    <= (state_nx == S_DONE);

         // A tick landing on the fetch cycle starts the next row's count.
         if (launch)
            tick_cnt <= '0;
         else if (fetch_go)
            tick_cnt <= frame_tick ? 8'd1 : 8'd0;
         else if (counting && frame_tick && !tick_full)
            tick_cnt <= tick_cnt + 8'd1;

         if (launch)
            overrun <= 1'b0;
         else if ((state == S_OFFER) && frame_tick && tick_full)
            overrun <= 1'b1;

         if (launch)
            row_index <= '0;
         else if (handshake && (row_index != LAST_ROW))
            row_index <= row_index + AW'(1);

         if (state == S_WAIT) begin
            row_data  <= rom_data;
            row_valid <= 1'b1;
         end else if (handshake) begin
            row_valid <= 1'b0;
         end
      end
   end

endmodule

// File: doc/chart_scroll_ctrl.md
CHART_SCROLL_CTRL -- requirements
Module: chart_scroll_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, bits per chart row: [7:6]=green, [5:4]=yellow, [3:2]=blue, [1:0]=orange; 00=none, 01=tail, 10=head.
REQ-002 SHALL have parameter DEPTH, default 2240, number of chart rows.
REQ-003 SHALL have parameter TICKS_PER_ROW, default 4, frame ticks per chart row, legal range 1..255.
REQ-004 SHALL have localparam AW = $clog2(DEPTH), the address width.
REQ-005 SHALL have port clk, input, 1, the single clock.
REQ-006 SHALL have port reset, input, 1, synchronous, active-high.
REQ-007 SHALL have port start, input, 1, begin or restart the song from row 0.
REQ-008 SHALL have port pause, input, 1, level, freezes scrolling.
REQ-009 SHALL have port frame_tick, input, 1, one-cycle pulse per video frame.
REQ-010 SHALL have port rom_en, output, 1, chart ROM read enable.
REQ-011 SHALL have port rom_addr, output, AW, chart ROM row address.
REQ-012 SHALL have port rom_data, input, WIDTH, ROM output, valid exactly 1 cycle after rom_en.
REQ-013 SHALL have port row_data, output, WIDTH, row offered to the highway renderer.
REQ-014 SHALL have port row_valid, output, 1, row_data offered.
REQ-015 SHALL have port row_ready, input, 1, renderer accepts the row.
REQ-016 SHALL have port row_index, output, AW, index of the next or offered row.
REQ-017 SHALL have port playing, output, 1, high in RUN, FETCH, WAIT and OFFER.
REQ-018 SHALL have port done, output, 1, high in DONE.
REQ-019 SHALL have port overrun, output, 1, sticky flag for a renderer stall that cost a row slot.

Function
REQ-020 SHALL implement FSM states IDLE, RUN, PAUSED, FETCH, WAIT, OFFER and DONE.
REQ-021 IDLE: start=1 SHALL go to RUN with row_index=0, tick_cnt=0 and overrun=0.
REQ-022 RUN: pause=1 SHALL go to PAUSED, taking priority over a fetch in the same cycle.
REQ-023 RUN: with pause=0 and tick_cnt==TICKS_PER_ROW, SHALL go to FETCH and clear tick_cnt to 0; any frame_tick in that same cycle is counted, giving 1.
REQ-024 PAUSED: tick_cnt SHALL hold and frame_tick SHALL be ignored; pause=0 SHALL return to RUN.
REQ-025 FETCH: rom_en=1 and rom_addr=row_index for exactly one cycle, then SHALL go to WAIT.
REQ-026 WAIT: SHALL register rom_data into row_data, set row_valid=1 on entry to OFFER, then go to OFFER.
REQ-027 OFFER: row_data and row_valid SHALL hold stable until row_valid && row_ready.
REQ-028 OFFER, on handshake: row_valid SHALL drop next cycle; if row_index==DEPTH-1 go to DONE, else increment row_index and go to RUN.
REQ-029 tick_cnt SHALL increment on frame_tick in RUN, FETCH, WAIT and OFFER, saturating at TICKS_PER_ROW.
REQ-030 If frame_tick arrives in OFFER while tick_cnt==TICKS_PER_ROW, SHALL set overrun=1 (sticky); the next FETCH then issues on the first RUN cycle.
REQ-031 pause SHALL be ignored in FETCH, WAIT and OFFER; it is honoured on return to RUN.
REQ-032 DONE: done=1 and row_valid=0; start=1 SHALL go to RUN per REQ-021.
REQ-033 start SHALL be ignored in RUN, PAUSED, FETCH, WAIT and OFFER.
REQ-034 Outside FETCH: rom_en SHALL be 0 and rom_addr SHALL equal row_index.
REQ-035 All outputs SHALL be registered except rom_addr; there is no combinational path from row_ready to row_valid.

Reset
REQ-036 On reset=1 at a clock edge, from any state including mid-OFFER, SHALL go to IDLE.
REQ-037 Reset SHALL set row_index=0, tick_cnt=0, row_data=0, row_valid=0, rom_en=0, playing=0, done=0 and overrun=0.
REQ-038 Reset SHALL take priority over start, pause and handshake in the same cycle.

Verification
REQ-039 Bench SHALL use DEPTH=4, TICKS_PER_ROW=2, row_ready=1, ROM rows 0x80,0x20,0x08,0x02, one frame_tick every 4 cycles. Pulse start -> four rows 0x80,0x20,0x08,0x02 each offered for one cycle, at least 8 cycles apart; done=1 after row 3; overrun=0.
REQ-040 Bench SHALL hold row_ready=0 for 20 cycles during the row-1 OFFER -> row_data=0x20 stable throughout; overrun=1; row 2 FETCH on the first RUN cycle after handshake.
REQ-041 Bench SHALL assert pause for 3 frame_ticks in RUN with tick_cnt=1 -> no rom_en while paused; tick_cnt=1 after release; fetch after one more frame_tick plus the saturation tick.
REQ-042 Bench SHALL assert reset during OFFER of row 2 -> next cycle IDLE, row_valid=0, row_index=0; start then replays from row 0.
REQ-043 Bench SHALL pulse start in RUN, then start in DONE -> first ignored (row_index unchanged); second restarts at row 0 with done=0 and overrun=0.
REQ-044 Bench SHALL check rom_en is never high for two consecutive cycles and rom_addr is never >=DEPTH.
